piso_frame_tx: RTL

- Parallel-in, serial-out framing transmitter.
- Sits directly upstream of the SISO shift register and drives its serial_in.
- Accepts a parallel word through a valid/ready handshake and emits one framed bit per clock: start bit, data bits, optional even parity, stop bit.
- Idle line level is 0, matching the downstream register's reset/idle input.

---
 rtl/piso_frame_tx.sv | 108 ++++++++++
 1 files changed

// File: rtl/piso_frame_tx.sv
// rtl/piso_frame_tx.sv - parallel-in serial-out framing transmitter
// Frames each accepted word as start(1), data, optional even parity, stop(0); idle line is 0.
module piso_frame_tx #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]    bit_cnt;
  logic             par_acc;
  logic             accept;
  logic             next_bit;

  // STOP also accepts so back-to-back frames need no idle gap.
  assign data_ready = rst_n && ((state == IDLE) || (state == STOP));
  assign accept     = data_valid && data_ready;
  assign next_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign shreg_nxt  = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_acc    <= 1'b0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, STOP: begin
          if (accept) begin
            state      <= START;
            shreg      <= data_in;
            bit_cnt    <= '0;
            par_acc    <= 1'b0;
            serial_out <= 1'b1;
            busy       <= 1'b1;
          end else begin
            state      <= IDLE;
            serial_out <= 1'b0;
            busy       <= 1'b0;
          end
        end
        START: begin
          state      <= DATA;
          bit_cnt    <= '0;
          serial_out <= next_bit;
          par_acc    <= par_acc ^ next_bit;
          shreg      <= shreg_nxt;
        end
        DATA: begin
          // Outputs are registered, so each bit is loaded one cycle before it is shown.
          if (bit_cnt == LAST_BIT) begin
            if (PARITY_EN) begin
              state      <= PARITY;
              serial_out <= par_acc;
            end else begin
              state      <= STOP;
              serial_out <= 1'b0;
              done       <= 1'b1;
            end
          end else begin
            bit_cnt    <= bit_cnt + 1'b1;
            serial_out <= next_bit;
            par_acc    <= par_acc ^ next_bit;
            shreg      <= shreg_nxt;
          end
        end
        PARITY: begin
          state      <= STOP;
          serial_out <= 1'b0;
          done       <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          serial_out <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
